// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write arbiter.
//   arb_state_e : two-state arbiter FSM encoding (IDLE, BURST)
//   idx_width() : bit width needed to index n items (never less than 1)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // Width of an index/counter covering 0..n-1. A single-item range still
  // needs one bit so the register never collapses to zero width.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority search: returns the lowest request index at
// or above base_i, wrapping cyclically past N-1 back to 0.
//   req_i   [N-1:0]  request vector
//   base_i  [W-1:0]  index with highest priority this cycle
//   found_o          at least one request is set
//   idx_o   [W-1:0]  winning index (0 when nothing is found)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] base_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  int unsigned cand;
  logic [W-1:0] cand_w;

  // Scan offsets from farthest to nearest so the nearest hit is written last
  // and wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that skips an assignment infers a latch.
    found_o = 1'b0;
    idx_o   = '0;
    cand    = 0;
    cand_w  = '0;
    for (int off = N - 1; off >= 0; off--) begin
      cand   = (int'(base_i) + off) % N;
      cand_w = W'(cand);
      if (req_i[cand_w]) begin
        found_o = 1'b1;
        idx_o   = cand_w;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Round-robin arbiter granting NUM_REQ writers bursts of up to BURST_LEN beats
// into one external FIFO. Data and write strobe pass through combinationally.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid  [NUM_REQ-1:0]        requester i holds a word
//   req_data   [NUM_REQ*DW-1:0]     word of requester i at [i*DW +: DW]
//   req_ready  [NUM_REQ-1:0]        requester i's word is accepted this cycle
//   fifo_full                       shared FIFO full flag
//   fifo_wren                       FIFO write strobe
//   fifo_wdata [DW-1:0]             FIFO write data (0 when not granted)
//   grant_id                        current grant holder, 0 when idle
//   busy                            high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wren,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [idx_width(NUM_REQ)-1:0] grant_id,
  output logic                          busy
);

  localparam int unsigned GW = idx_width(NUM_REQ);
  localparam int unsigned CW = idx_width(BURST_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;

  logic                  pick_found;
  logic [GW-1:0]         pick_idx;
  logic                  grant_valid;
  logic                  beat_accept;
  logic                  burst_done;
  logic [GW-1:0]         next_ptr;
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_rr_pick (
    .req_i   (req_valid),
    .base_i  (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign grant_valid = req_valid[grant_q];
  assign beat_accept = (state_q == BURST) & grant_valid & ~fifo_full;
  assign next_ptr    = (grant_q == LAST_REQ) ? '0 : grant_q + 1'b1;

  // State register: FSM state, grant holder, round-robin pointer, beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values, independent of statement order.
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    burst_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          grant_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        // Holder withdrawing ends the burst; full alone only stalls it.
        if (!grant_valid) begin
          burst_done = 1'b1;
        end else if (beat_accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == LAST_BEAT) burst_done = 1'b1;
        end
        if (burst_done) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: only the holder is ever offered ready, and the data mux is
  // forced to zero outside a burst.
  always_comb begin
    req_ready  = '0;
    fifo_wren  = beat_accept;
    fifo_wdata = '0;
    busy       = (state_q == BURST);
    if (state_q == BURST) begin
      req_ready[grant_q] = ~fifo_full;
      fifo_wdata         = data_arr[grant_q];
    end
  end

  assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (defaults: 4 requesters, 8-bit data,
// 4-beat bursts). Each requester presents an incrementing word stream; a
// transaction-level model of grants, bursts and the round-robin pointer
// predicts every output each cycle, followed by directed scenario checks and
// a randomized run.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wren;
  logic [DW-1:0]   fifo_wdata;
  logic [1:0]      grant_id;
  logic            busy;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wren  (fifo_wren),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Transaction model: who holds the grant, beats written in this burst, and
  // where the next search starts. Requester i's current word is dbase+sent.
  bit m_busy;
  int m_holder, m_beats, m_ptr;
  int sent  [N];
  int dbase [N];

  logic [DW-1:0] wr_log[$];
  int            grant_log[$];
  bit            prev_busy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] word_of(input int i);
    return DW'(dbase[i] + sent[i]);
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic full);
    req_valid = v;
    fifo_full = full;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word_of(i);
  endtask

  task automatic model_reset();
    m_busy    = 1'b0;
    m_holder  = 0;
    m_beats   = 0;
    m_ptr     = 0;
    prev_busy = 1'b0;
  endtask

  task automatic compare_outputs(input string tag);
    logic [N-1:0]  e_ready;
    logic          e_wren;
    logic [DW-1:0] e_wdata;
    int            e_gid;
    e_ready = '0;
    e_wren  = 1'b0;
    e_wdata = '0;
    e_gid   = 0;
    if (m_busy) begin
      e_gid   = m_holder;
      e_wdata = word_of(m_holder);
      if (!fifo_full) e_ready[m_holder] = 1'b1;
      e_wren = req_valid[m_holder] && !fifo_full;
    end
    check({tag, ".busy"},  32'(busy),       32'(m_busy));
    check({tag, ".gid"},   32'(grant_id),   32'(e_gid));
    check({tag, ".ready"}, 32'(req_ready),  32'(e_ready));
    check({tag, ".wren"},  32'(fifo_wren),  32'(e_wren));
    check({tag, ".wdata"}, 32'(fifo_wdata), 32'(e_wdata));
    compared++;
    assert (!(fifo_wren && fifo_full)) else begin
      mismatched++;
      $error("FAIL %s.wren_while_full: observed=1 expected=0", tag);
    end
  endtask

  task automatic model_update(input logic [N-1:0] v, input logic full);
    int c;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (v[c]) begin
          m_busy   = 1'b1;
          m_holder = c;
          m_beats  = 0;
          break;
        end
      end
    end else if (!v[m_holder]) begin
      m_busy = 1'b0;
      m_ptr  = (m_holder + 1) % N;
    end else if (!full) begin
      sent[m_holder]++;
      m_beats++;
      if (m_beats == BL) begin
        m_busy = 1'b0;
        m_ptr  = (m_holder + 1) % N;
      end
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, advance model.
  task automatic step(input logic [N-1:0] v, input logic full, input string tag);
    drive(v, full);
    @(negedge clk);
    compare_outputs(tag);
    if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
    prev_busy = busy;
    if (fifo_wren) wr_log.push_back(fifo_wdata);
    model_update(v, full);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] v;
    logic         full;
    int           n_before, sent_before, sent_after;

    for (int i = 0; i < N; i++) begin
      sent[i]  = 0;
      dbase[i] = i * 64 + 1;
    end
    model_reset();
    rst_n = 1'b0;
    drive('1, 1'b0);
    #3;
    compare_outputs("reset");
    @(posedge clk);
    #1;
    compare_outputs("reset_hold");
    rst_n = 1'b1;

    // Single requester 2 with words 0x10..0x15.
    dbase[2] = 'h10;
    wr_log.delete();
    for (int s = 0; s < 8; s++) step(4'b0100, 1'b0, "single");
    step(4'b0000, 1'b0, "single_drop");
    check("single.count", 32'(wr_log.size()), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < wr_log.size()) check($sformatf("single.word%0d", k), 32'(wr_log[k]), 32'('h10 + k));
    end

    // All requesters valid continuously from a fresh reset.
    apply_reset();
    grant_log.delete();
    wr_log.delete();
    for (int s = 0; s < 25; s++) step(4'b1111, 1'b0, "all");
    check("all.grants", 32'(grant_log.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < grant_log.size()) check($sformatf("all.grant%0d", k), 32'(grant_log[k]), 32'(k % 4));
    end
    check("all.writes", 32'(wr_log.size()), 32'd20);

    // FIFO full for three cycles after beat 1 of the grant to requester 1.
    wr_log.delete();
    for (int s = 0; s < 3; s++) step(4'b1111, 1'b0, "stall_pre");
    n_before = wr_log.size();
    for (int s = 0; s < 3; s++) step(4'b1111, 1'b1, "stall_full");
    check("stall.no_write", 32'(wr_log.size()), 32'(n_before));
    for (int s = 0; s < 2; s++) step(4'b1111, 1'b0, "stall_post");
    check("stall.writes", 32'(wr_log.size()), 32'd4);

    // Holder (requester 2) drops valid after two beats; next grant is 3.
    grant_log.delete();
    for (int s = 0; s < 3; s++) step(4'b1111, 1'b0, "drop_pre");
    step(4'b1011, 1'b0, "drop_exit");
    step(4'b1011, 1'b0, "drop_regrant");
    step(4'b1011, 1'b0, "drop_b0");
    check("drop.grants", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      check("drop.first", 32'(grant_log[0]), 32'd2);
      check("drop.next",  32'(grant_log[1]), 32'd3);
    end

    // Requester 3 holds the grant (beat 0 already written); write beat 1,
    // then pulse reset in the middle of beat 2.
    step(4'b1000, 1'b0, "rst_b1");
    drive(4'b1000, 1'b0);
    #1;
    compare_outputs("rst_pre");
    rst_n = 1'b0;
    #1;
    check("rst.busy",  32'(busy),       32'd0);
    check("rst.wren",  32'(fifo_wren),  32'd0);
    check("rst.ready", 32'(req_ready),  32'd0);
    check("rst.wdata", 32'(fifo_wdata), 32'd0);
    check("rst.gid",   32'(grant_id),   32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
    step(4'b1001, 1'b0, "rst_idle");
    step(4'b1001, 1'b0, "rst_grant");
    check("rst.regrant_cnt", 32'(grant_log.size()), 32'd1);
    if (grant_log.size() == 1) check("rst.regrant", 32'(grant_log[0]), 32'd0);

    // Randomized traffic: valid bits toggle occasionally, FIFO full ~25%.
    wr_log.delete();
    sent_before = 0;
    for (int i = 0; i < N; i++) sent_before += sent[i];
    v = 4'b1111;
    for (int s = 0; s < 600; s++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) v[i] = ~v[i];
      end
      full = ($urandom_range(0, 3) == 0);
      step(v, full, "rand");
    end
    sent_after = 0;
    for (int i = 0; i < N; i++) sent_after += sent[i];
    check("rand.total_writes", 32'(wr_log.size()), 32'(sent_after - sent_before));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
